// File: rtl/sysio_axi_arb_pkg.sv
// Shared definitions for the sysio two-master AXI4-Lite arbiter.
//   MstIdxW    : width of a master index (two masters)
//   MemAddrBus : system address bus width
//   MemBus     : system data bus width
//   rd_state_e : read-channel FSM encoding
package sysio_axi_arb_pkg;

  localparam int unsigned MstIdxW    = 1;
  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned MemBus     = 32;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sysio_arb_rr2.sv
// 2-way arbiter grant with a round-robin pointer register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per master
//   advance    : the current grant completed a handshake this cycle
//   gnt_idx    : index of the granted master (0 when nobody requests)
// Build option SYSIO_ARB_FIXED_PRIO_EN: master 0 always wins, no pointer.
module sysio_arb_rr2
  import sysio_axi_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic               advance,
  output logic [MstIdxW-1:0] gnt_idx
);

`ifdef SYSIO_ARB_FIXED_PRIO_EN

  assign gnt_idx = ~req[0] & req[1];

  // Pointer-less build; keep the common port list.
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, advance};

`else

  logic [MstIdxW-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      // The master just served drops to lowest priority.
      ptr_q <= ~gnt_idx;
    end
  end

  always_comb begin
    unique case (req)
      2'b11:   gnt_idx = ptr_q;
      2'b10:   gnt_idx = 1'b1;
      default: gnt_idx = 1'b0;
    endcase
  end

`endif

endmodule

// File: rtl/sysio_axi_arb.sv
// Two-master to one-slave AXI4-Lite arbiter in front of the sysio slave port.
// Master 0 is the core LSU, master 1 the debug/DMA master. Writes (AW+W issued
// together, no B channel) and reads arbitrate independently; at most one read
// is outstanding, and its R beat is routed by the registered owner index.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0_* / m1_*         : master-side AW, W, AR, R channels
//   s_*                 : slave-side AW, W, AR, R channels toward sysio
// Build option SYSIO_ARB_FIXED_PRIO_EN: master 0 wins all contention.
module sysio_axi_arb
  import sysio_axi_arb_pkg::*;
#(
  parameter int unsigned AW = MemAddrBus,
  parameter int unsigned DW = MemBus
) (
  input  logic          clk,
  input  logic          rst_n,
  // Master 0
  input  logic [AW-1:0] m0_awaddr,
  input  logic          m0_awvalid,
  output logic          m0_awready,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wstrb,
  input  logic          m0_wvalid,
  output logic          m0_wready,
  input  logic [AW-1:0] m0_araddr,
  input  logic          m0_arvalid,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  // Master 1
  input  logic [AW-1:0] m1_awaddr,
  input  logic          m1_awvalid,
  output logic          m1_awready,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_wvalid,
  output logic          m1_wready,
  input  logic [AW-1:0] m1_araddr,
  input  logic          m1_arvalid,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  // Slave (sysio)
  output logic [AW-1:0] s_awaddr,
  output logic          s_awvalid,
  input  logic          s_awready,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wstrb,
  output logic          s_wvalid,
  input  logic          s_wready,
  output logic [AW-1:0] s_araddr,
  output logic          s_arvalid,
  input  logic          s_arready,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rvalid,
  output logic          s_rready
);

  logic [1:0]         wr_req, rd_req;
  logic [MstIdxW-1:0] wr_gnt, rd_gnt;
  logic               wr_hs, ar_allow, ar_hs, r_hs, r_pend;
  rd_state_e          rd_state_q, rd_state_d;
  logic [MstIdxW-1:0] rd_owner_q;

  // ---------------------------------------------------------------- writes
  assign wr_req = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};

  sysio_arb_rr2 u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .advance (wr_hs),
    .gnt_idx (wr_gnt)
  );

  assign s_awaddr  = wr_gnt[0] ? m1_awaddr : m0_awaddr;
  assign s_wdata   = wr_gnt[0] ? m1_wdata  : m0_wdata;
  assign s_wstrb   = wr_gnt[0] ? m1_wstrb  : m0_wstrb;
  // Outputs held quiet during reset regardless of master activity.
  assign s_awvalid = rst_n & (|wr_req);
  assign s_wvalid  = s_awvalid;
  assign wr_hs     = s_awvalid & s_awready & s_wready;

  assign m0_awready = wr_hs & ~wr_gnt[0];
  assign m0_wready  = wr_hs & ~wr_gnt[0];
  assign m1_awready = wr_hs &  wr_gnt[0];
  assign m1_wready  = wr_hs &  wr_gnt[0];

  // ----------------------------------------------------------------- reads
  assign rd_req = {m1_arvalid, m0_arvalid};
  assign r_pend = (rd_state_q == RD_WAIT);

  assign s_rready = rd_owner_q[0] ? m1_rready : m0_rready;
  assign r_hs     = r_pend & s_rvalid & s_rready;
  // A new AR may only go out when nothing is outstanding after this cycle.
  assign ar_allow = ~r_pend | r_hs;

  sysio_arb_rr2 u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .advance (ar_hs),
    .gnt_idx (rd_gnt)
  );

  assign s_araddr  = rd_gnt[0] ? m1_araddr : m0_araddr;
  assign s_arvalid = rst_n & (|rd_req) & ar_allow;
  assign ar_hs     = s_arvalid & s_arready;

  assign m0_arready = ar_hs & ~rd_gnt[0];
  assign m1_arready = ar_hs &  rd_gnt[0];

  // R routing uses the registered owner; rvalid is only honoured while a read
  // is outstanding so an async reset silences it immediately.
  assign m0_rvalid = r_pend & ~rd_owner_q[0] & s_rvalid;
  assign m1_rvalid = r_pend &  rd_owner_q[0] & s_rvalid;
  assign m0_rdata  = (r_pend & ~rd_owner_q[0]) ? s_rdata : '0;
  assign m1_rdata  = (r_pend &  rd_owner_q[0]) ? s_rdata : '0;

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (ar_hs) rd_state_d = RD_WAIT;
      RD_WAIT: if (r_hs && !ar_hs) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_owner_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) rd_owner_q <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_sysio_axi_arb.sv
// Self-checking bench for sysio_axi_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the arbiter.
module tb_sysio_axi_arb;

`ifdef SYSIO_ARB_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, m0_araddr, m1_araddr;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid, m0_arvalid, m1_arvalid;
  logic        m0_rready, m1_rready;
  logic        m0_awready, m1_awready, m0_wready, m1_wready, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_arvalid, s_rready;
  logic        s_awready, s_wready, s_arready, s_rvalid;

  sysio_axi_arb dut (
    .clk        (clk),        .rst_n      (rst_n),
    .m0_awaddr  (m0_awaddr),  .m0_awvalid (m0_awvalid), .m0_awready (m0_awready),
    .m0_wdata   (m0_wdata),   .m0_wstrb   (m0_wstrb),   .m0_wvalid  (m0_wvalid),
    .m0_wready  (m0_wready),  .m0_araddr  (m0_araddr),  .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready), .m0_rdata   (m0_rdata),   .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m1_awaddr  (m1_awaddr),  .m1_awvalid (m1_awvalid), .m1_awready (m1_awready),
    .m1_wdata   (m1_wdata),   .m1_wstrb   (m1_wstrb),   .m1_wvalid  (m1_wvalid),
    .m1_wready  (m1_wready),  .m1_araddr  (m1_araddr),  .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready), .m1_rdata   (m1_rdata),   .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .s_awaddr   (s_awaddr),   .s_awvalid  (s_awvalid),  .s_awready  (s_awready),
    .s_wdata    (s_wdata),    .s_wstrb    (s_wstrb),    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),   .s_araddr   (s_araddr),   .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),  .s_rdata    (s_rdata),    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: round-robin pointers, read owner, read outstanding,
  // and the data the modelled sysio slave will return.
  bit          m_wr_ptr, m_rd_ptr, m_owner, m_out;
  logic [31:0] sl_data;
  bit          e_wg, e_whs, e_rg, e_arhs, e_rhs;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr_ptr = 1'b0; m_rd_ptr = 1'b0; m_owner = 1'b0; m_out = 1'b0;
    sl_data  = 32'h0;
  endtask

  task automatic idle_inputs();
    m0_awvalid = 0; m1_awvalid = 0; m0_wvalid = 0; m1_wvalid = 0;
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    m0_awaddr = 32'h100; m1_awaddr = 32'h200; m0_wdata = 32'h11; m1_wdata = 32'h22;
    m0_wstrb = 4'h1; m1_wstrb = 4'h2; m0_araddr = 32'h300; m1_araddr = 32'h400;
    s_awready = 1; s_wready = 1; s_arready = 1; s_rvalid = 0; s_rdata = 32'h0BAD_0BAD;
  endtask

  // Modelled sysio slave: presents its pending read data when asked to.
  task automatic slave_r(input bit v);
    s_rvalid = v & m_out;
    s_rdata  = m_out ? sl_data : 32'h0BAD_0BAD;
  endtask

  task automatic rand_inputs();
    m0_awvalid = 1'($urandom_range(0, 1)); m1_awvalid = 1'($urandom_range(0, 1));
    m0_wvalid  = 1'($urandom_range(0, 1)); m1_wvalid  = 1'($urandom_range(0, 1));
    m0_arvalid = 1'($urandom_range(0, 1)); m1_arvalid = 1'($urandom_range(0, 1));
    m0_rready  = 1'($urandom_range(0, 1)); m1_rready  = 1'($urandom_range(0, 1));
    m0_awaddr = $urandom; m1_awaddr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
    m0_wstrb = 4'($urandom); m1_wstrb = 4'($urandom);
    m0_araddr = $urandom; m1_araddr = $urandom;
    s_awready = ($urandom_range(0, 3) != 0);
    s_wready  = ($urandom_range(0, 3) != 0);
    s_arready = ($urandom_range(0, 2) != 0);
    slave_r($urandom_range(0, 3) != 0);
    if (!s_rvalid) s_rdata = $urandom;
  endtask

  // Expected outputs for the current inputs, derived from the arbitration rules.
  task automatic model_check();
    bit wq0, wq1, wany, sr, rany, allow, svld;
    wq0  = m0_awvalid & m0_wvalid;
    wq1  = m1_awvalid & m1_wvalid;
    wany = wq0 | wq1;
    e_wg  = (wq0 && wq1) ? (Fixed ? 1'b0 : m_wr_ptr) : wq1;
    e_whs = wany && s_awready && s_wready;
    check_eq("s_awvalid", s_awvalid, wany);
    check_eq("s_wvalid", s_wvalid, wany);
    if (wany) begin
      check_eq("s_awaddr", s_awaddr, e_wg ? m1_awaddr : m0_awaddr);
      check_eq("s_wdata", s_wdata, e_wg ? m1_wdata : m0_wdata);
      check_eq("s_wstrb", s_wstrb, e_wg ? m1_wstrb : m0_wstrb);
    end
    check_eq("m0_awready", m0_awready, e_whs && !e_wg);
    check_eq("m0_wready", m0_wready, e_whs && !e_wg);
    check_eq("m1_awready", m1_awready, e_whs && e_wg);
    check_eq("m1_wready", m1_wready, e_whs && e_wg);

    sr = m_owner ? m1_rready : m0_rready;
    check_eq("s_rready", s_rready, sr);
    e_rhs  = m_out && s_rvalid && sr;
    allow  = !m_out || e_rhs;
    rany   = m0_arvalid | m1_arvalid;
    e_rg   = (m0_arvalid && m1_arvalid) ? (Fixed ? 1'b0 : m_rd_ptr) : m1_arvalid;
    svld   = rany && allow;
    e_arhs = svld && s_arready;
    check_eq("s_arvalid", s_arvalid, svld);
    if (svld) check_eq("s_araddr", s_araddr, e_rg ? m1_araddr : m0_araddr);
    check_eq("m0_arready", m0_arready, e_arhs && !e_rg);
    check_eq("m1_arready", m1_arready, e_arhs && e_rg);
    check_eq("m0_rvalid", m0_rvalid, m_out && !m_owner && s_rvalid);
    check_eq("m1_rvalid", m1_rvalid, m_out && m_owner && s_rvalid);
    check_eq("m0_rdata", m0_rdata, (m_out && !m_owner) ? s_rdata : 32'h0);
    check_eq("m1_rdata", m1_rdata, (m_out && m_owner) ? s_rdata : 32'h0);
  endtask

  // Called just after inputs settle; checks, then advances the model a cycle.
  task automatic run_cycle();
    model_check();
    @(posedge clk);
    if (e_whs) m_wr_ptr = ~e_wg;
    if (e_arhs) begin
      m_owner  = e_rg;
      m_rd_ptr = ~e_rg;
      m_out    = 1'b1;
      sl_data  = $urandom;
    end else if (e_rhs) begin
      m_out = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    // Everything requesting while in reset: outputs must stay quiet.
    m0_awvalid = 1; m0_wvalid = 1; m1_arvalid = 1; m0_arvalid = 1;
    m0_rready = 1; s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_s_awvalid", s_awvalid, 0);
    check_eq("rst_s_wvalid", s_wvalid, 0);
    check_eq("rst_s_arvalid", s_arvalid, 0);
    check_eq("rst_m0_awready", m0_awready, 0);
    check_eq("rst_m0_wready", m0_wready, 0);
    check_eq("rst_m0_arready", m0_arready, 0);
    check_eq("rst_m1_arready", m1_arready, 0);
    check_eq("rst_m0_rvalid", m0_rvalid, 0);
    check_eq("rst_m1_rvalid", m1_rvalid, 0);
    check_eq("rst_m0_rdata", m0_rdata, 0);
    check_eq("rst_m1_rdata", m1_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // Write contention from a fresh pointer.
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      m0_awvalid = 1; m0_wvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
      #1;
      check_eq("cont_m0_awready", m0_awready, Fixed ? 1'b1 : (k % 2 == 0));
      check_eq("cont_m1_awready", m1_awready, Fixed ? 1'b0 : (k % 2 == 1));
      run_cycle();
    end

    // Single write from m0.
    idle_inputs();
    m0_awvalid = 1; m0_wvalid = 1; m0_awaddr = 32'h404; m0_wdata = 32'hDEAD_BEEF;
    m0_wstrb = 4'hF;
    #1;
    check_eq("wr_s_awaddr", s_awaddr, 32'h404);
    check_eq("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check_eq("wr_m0_awready", m0_awready, 1);
    check_eq("wr_m1_awready", m1_awready, 0);
    check_eq("wr_m1_wready", m1_wready, 0);
    run_cycle();

    // m1 read routed back to m1 only.
    idle_inputs();
    m1_arvalid = 1; m1_araddr = 32'h400;
    #1;
    check_eq("rd_m1_arready", m1_arready, 1);
    run_cycle();
    idle_inputs(); slave_r(1); m1_rready = 1;
    #1;
    check_eq("rd_m1_rvalid", m1_rvalid, 1);
    check_eq("rd_m1_rdata", m1_rdata, sl_data);
    check_eq("rd_m0_rvalid", m0_rvalid, 0);
    run_cycle();

    // Back-to-back: m1 AR accepted alongside m0 R handshake.
    idle_inputs(); m0_arvalid = 1; m0_araddr = 32'h408;
    #1; run_cycle();
    idle_inputs(); slave_r(1); m0_rready = 1; m1_arvalid = 1; m1_araddr = 32'h40C;
    #1;
    check_eq("b2b_m0_rvalid", m0_rvalid, 1);
    check_eq("b2b_m1_arready", m1_arready, 1);
    run_cycle();
    idle_inputs(); slave_r(1); m0_rready = 1;
    #1;
    check_eq("b2b_m0_rvalid_after", m0_rvalid, 0);
    check_eq("b2b_m1_rvalid", m1_rvalid, 1);
    run_cycle();
    idle_inputs(); slave_r(1); m1_rready = 1;
    #1; run_cycle();

    // R backpressure blocks the next AR.
    idle_inputs(); m0_arvalid = 1;
    #1; run_cycle();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); slave_r(1); m1_arvalid = 1;
      #1;
      check_eq("bp_s_arvalid", s_arvalid, 0);
      check_eq("bp_m1_arready", m1_arready, 0);
      run_cycle();
    end
    idle_inputs(); slave_r(1); m1_arvalid = 1; m0_rready = 1;
    #1;
    check_eq("bp_release_m1_arready", m1_arready, 1);
    run_cycle();
    idle_inputs(); slave_r(1); m1_rready = 1;
    #1; run_cycle();

    // Asynchronous reset while a read is outstanding.
    idle_inputs(); m0_arvalid = 1;
    #1; run_cycle();
    idle_inputs(); slave_r(1);
    #1;
    check_eq("arst_pre_m0_rvalid", m0_rvalid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_m0_rvalid", m0_rvalid, 0);
    check_eq("arst_m1_rvalid", m1_rvalid, 0);
    check_eq("arst_m0_rdata", m0_rdata, 0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m1_arvalid = 1; m1_araddr = 32'h500;
    #1;
    check_eq("arst_next_m1_arready", m1_arready, 1);
    check_eq("arst_next_s_araddr", s_araddr, 32'h500);
    run_cycle();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      #1;
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
